// File: rtl/prog_mem_loader.sv
// Program memory for the Salamander-4 core: CLEAR sweep, streamed valid/ready load, registered fetch.
// Optional feature macro PROG_MEM_PARITY_EN adds a stored even-parity bit per word and the fetch_perr port.
module prog_mem_loader #(
  parameter int                   DATA_SIZE = 6,
  parameter int                   ADDR_SIZE = 5,
  parameter logic [DATA_SIZE-1:0] CLEAR_VAL = {DATA_SIZE{1'b0}}
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [DATA_SIZE-1:0] load_data,
  input  logic                 load_last,
  input  logic                 reload,
  output logic [ADDR_SIZE:0]   prog_len,
  output logic                 run,
  input  logic                 fetch_req,
  input  logic [ADDR_SIZE-1:0] fetch_addr,
`ifdef PROG_MEM_PARITY_EN
  output logic                 fetch_perr,
`endif
  output logic                 fetch_valid,
  output logic [DATA_SIZE-1:0] fetch_data,
  output logic                 fetch_oob
);

  localparam int DEPTH = 2 ** ADDR_SIZE;
  localparam int LEN_W = ADDR_SIZE + 1;
`ifdef PROG_MEM_PARITY_EN
  localparam int WORD_W = DATA_SIZE + 1;
`else
  localparam int WORD_W = DATA_SIZE;
`endif
  localparam logic [ADDR_SIZE-1:0] PTR_MAX = {ADDR_SIZE{1'b1}};

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  // Storage word: data in the low bits, parity (when enabled) on top.
  function automatic logic [WORD_W-1:0] encode_f(input logic [DATA_SIZE-1:0] d);
`ifdef PROG_MEM_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

`ifdef PROG_MEM_PARITY_EN
  // Even parity over data+parity is zero for an intact word.
  function automatic logic parity_err_f(input logic [WORD_W-1:0] w);
    return ^w;
  endfunction
`endif

  logic [WORD_W-1:0]    mem_q [DEPTH];
  state_t               state_q, state_d;
  logic [ADDR_SIZE-1:0] ptr_q, ptr_d;
  logic [LEN_W-1:0]     prog_len_q, prog_len_d;
  logic                 load_ready_q, load_ready_d;
  logic                 run_q, run_d;
  logic                 fetch_valid_q, fetch_valid_d;
  logic [DATA_SIZE-1:0] fetch_data_q, fetch_data_d;
  logic                 fetch_oob_q, fetch_oob_d;
  logic                 fetch_perr_q, fetch_perr_d;
  logic                 we_s;
  logic [ADDR_SIZE-1:0] waddr_s;
  logic [WORD_W-1:0]    wdata_s;
  logic [WORD_W-1:0]    rword_s;

  // Next-state, memory write port and registered-output computation.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    prog_len_d    = prog_len_q;
    load_ready_d  = load_ready_q;
    run_d         = run_q;
    fetch_valid_d = 1'b0;
    fetch_data_d  = fetch_data_q;
    fetch_oob_d   = fetch_oob_q;
    fetch_perr_d  = fetch_perr_q;
    we_s          = 1'b0;
    waddr_s       = ptr_q;
    wdata_s       = encode_f(CLEAR_VAL);
    rword_s       = mem_q[fetch_addr];
    case (state_q)
      S_CLEAR: begin
        we_s  = 1'b1;
        ptr_d = ptr_q + ADDR_SIZE'(1);
        if (ptr_q == PTR_MAX) begin
          state_d      = S_LOAD;
          load_ready_d = 1'b1;
        end else begin
          state_d = S_CLEAR;
        end
      end
      S_LOAD: begin
        if (load_valid && load_ready_q) begin
          we_s       = 1'b1;
          wdata_s    = encode_f(load_data);
          ptr_d      = ptr_q + ADDR_SIZE'(1);
          prog_len_d = prog_len_q + LEN_W'(1);
          // A full memory ends the load even without load_last.
          if (load_last || (ptr_q == PTR_MAX)) begin
            state_d      = S_RUN;
            load_ready_d = 1'b0;
            run_d        = 1'b1;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_RUN: begin
        if (fetch_req) begin
          fetch_valid_d = 1'b1;
          fetch_data_d  = rword_s[DATA_SIZE-1:0];
          fetch_oob_d   = ({1'b0, fetch_addr} >= prog_len_q);
`ifdef PROG_MEM_PARITY_EN
          fetch_perr_d  = parity_err_f(rword_s);
`else
          fetch_perr_d  = 1'b0;
`endif
        end else begin
          fetch_valid_d = 1'b0;
        end
        // Memory is deliberately not cleared on reload.
        if (reload) begin
          state_d      = S_LOAD;
          ptr_d        = {ADDR_SIZE{1'b0}};
          prog_len_d   = {LEN_W{1'b0}};
          run_d        = 1'b0;
          load_ready_d = 1'b1;
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d      = S_CLEAR;
        ptr_d        = {ADDR_SIZE{1'b0}};
        load_ready_d = 1'b0;
        run_d        = 1'b0;
      end
    endcase
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_CLEAR;
      ptr_q         <= {ADDR_SIZE{1'b0}};
      prog_len_q    <= {LEN_W{1'b0}};
      load_ready_q  <= 1'b0;
      run_q         <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_data_q  <= {DATA_SIZE{1'b0}};
      fetch_oob_q   <= 1'b0;
      fetch_perr_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      prog_len_q    <= prog_len_d;
      load_ready_q  <= load_ready_d;
      run_q         <= run_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_data_q  <= fetch_data_d;
      fetch_oob_q   <= fetch_oob_d;
      fetch_perr_q  <= fetch_perr_d;
    end
  end

  // Storage array; contents are initialised by the CLEAR sweep, not by reset.
  always_ff @(posedge clk) begin
    if (!rst && we_s) begin
      mem_q[waddr_s] <= wdata_s;
    end
  end

  assign load_ready  = load_ready_q;
  assign prog_len    = prog_len_q;
  assign run         = run_q;
  assign fetch_valid = fetch_valid_q;
  assign fetch_data  = fetch_data_q;
  assign fetch_oob   = fetch_oob_q;
`ifdef PROG_MEM_PARITY_EN
  assign fetch_perr  = fetch_perr_q;
`endif

endmodule

// File: tb/tb_prog_mem_loader.sv
// Self-checking bench for prog_mem_loader: cycle-level reference model plus directed and random loads/fetches.
// Builds with or without PROG_MEM_PARITY_EN.
module tb_prog_mem_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic [5:0] load_data = 6'd0;
  logic       load_last = 1'b0;
  logic       reload = 1'b0;
  logic [5:0] prog_len;
  logic       run;
  logic       fetch_req = 1'b0;
  logic [4:0] fetch_addr = 5'd0;
  logic       fetch_valid;
  logic [5:0] fetch_data;
  logic       fetch_oob;
`ifdef PROG_MEM_PARITY_EN
  logic       fetch_perr;
`endif

  int errors = 0;
  int checks = 0;

  prog_mem_loader #(.DATA_SIZE(6), .ADDR_SIZE(5), .CLEAR_VAL(6'd0)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data), .load_last(load_last),
    .reload(reload), .prog_len(prog_len), .run(run),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
`ifdef PROG_MEM_PARITY_EN
    .fetch_perr(fetch_perr),
`endif
    .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_oob(fetch_oob)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks what the memory must hold and what outputs follow each edge.
  int       clear_left = 0;
  bit       loading = 0;
  bit       running = 0;
  int       m_len = 0;
  bit [5:0] m_mem [32];
  bit       e_fv = 0;
  bit [5:0] e_fd = 0;
  bit       e_oob = 0;
  bit       chk_en = 0;

  always @(posedge clk) begin
    if (rst) begin
      clear_left = 32; loading = 0; running = 0; m_len = 0; e_fv = 0; chk_en = 1;
    end else begin
      e_fv = 0;
      if (clear_left > 0) begin
        m_mem[32 - clear_left] = 6'd0;
        clear_left--;
        if (clear_left == 0) loading = 1;
      end else if (loading) begin
        if (load_valid) begin
          m_mem[m_len] = load_data;
          m_len++;
          if (load_last || m_len == 32) begin loading = 0; running = 1; end
        end
      end else if (running) begin
        if (fetch_req) begin
          e_fv = 1; e_fd = m_mem[fetch_addr]; e_oob = (int'(fetch_addr) >= m_len);
        end
        if (reload) begin running = 0; loading = 1; m_len = 0; end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("load_ready", int'(load_ready), int'(loading));
      check("run", int'(run), int'(running));
      check("prog_len", int'(prog_len), m_len);
      check("fetch_valid", int'(fetch_valid), int'(e_fv));
      if (e_fv) begin
        check("fetch_data", int'(fetch_data), int'(e_fd));
        check("fetch_oob", int'(fetch_oob), int'(e_oob));
      end
    end
  end

  bit [5:0] ld_words [32];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; load_valid = 1'b0; fetch_req = 1'b0; reload = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic wait_ready(input string name, input int exp_cycles);
    int n = 0;
    while (!load_ready && n < 100) begin tick(); n++; end
    check(name, n, exp_cycles);
  endtask

  task automatic load_seq(input int n, input bit use_last, input bit noisy);
    bit hs;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        load_valid = 1'b0; load_data = 6'($urandom);
        fetch_req = noisy ? 1'($urandom) : 1'b0; fetch_addr = 5'($urandom);
        tick();
      end
      load_valid = 1'b1; load_data = ld_words[i]; load_last = use_last && (i == n - 1);
      fetch_req = noisy ? 1'($urandom) : 1'b0; fetch_addr = 5'($urandom);
      hs = 0;
      for (int t = 0; t < 50 && !hs; t++) begin
        @(negedge clk); hs = load_ready; @(posedge clk); #1;
      end
      if (!hs) check("load_handshake", 0, 1);
    end
    load_valid = 1'b0; load_last = 1'b0; fetch_req = 1'b0;
  endtask

  task automatic fetch_one(input int a);
    fetch_req = 1'b1; fetch_addr = 5'(a);
    tick();
    fetch_req = 1'b0;
  endtask

  task automatic pulse_reload();
    reload = 1'b1; tick(); reload = 1'b0;
  endtask

  initial begin
    // Reset and CLEAR length
    do_reset();
    check("ready_after_reset", int'(load_ready), 0);
    wait_ready("clear_cycles", 32);
    check("len_after_clear", int'(prog_len), 0);
    check("run_after_clear", int'(run), 0);

    // Short program with load_last
    ld_words[0] = 6'h11; ld_words[1] = 6'h22; ld_words[2] = 6'h3F;
    load_seq(3, 1'b1, 1'b0);
    check("run_after_last", int'(run), 1);
    check("len_3", int'(prog_len), 3);
    fetch_one(1);
    check("fetch1_valid", int'(fetch_valid), 1);
    check("fetch1_data", int'(fetch_data), 'h22);
    check("fetch1_oob", int'(fetch_oob), 0);
    fetch_one(5);
    check("fetch5_data", int'(fetch_data), 0);
    check("fetch5_oob", int'(fetch_oob), 1);
    fetch_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fetch_addr = 5'(i); tick();
      check("b2b_data", int'(fetch_data), int'(ld_words[i]));
    end
    fetch_req = 1'b0; tick();
    check("idle_no_valid", int'(fetch_valid), 0);

    // Full memory without load_last
    pulse_reload();
    for (int i = 0; i < 32; i++) ld_words[i] = 6'(i ^ 'h15);
    load_seq(32, 1'b0, 1'b0);
    check("full_len", int'(prog_len), 32);
    check("full_run", int'(run), 1);
    fetch_one(31);
    check("fetch31_data", int'(fetch_data), 'h0A);
    load_valid = 1'b1; tick(); tick();
    check("ready_in_run", int'(load_ready), 0);
    load_valid = 1'b0;

    // Reload with concurrent fetch, then a one-word program
    reload = 1'b1; fetch_req = 1'b1; fetch_addr = 5'd31; tick();
    reload = 1'b0; fetch_req = 1'b0;
    check("reload_fetch_valid", int'(fetch_valid), 1);
    check("reload_fetch_data", int'(fetch_data), 'h0A);
    check("reload_run", int'(run), 0);
    ld_words[0] = 6'h2A;
    load_seq(1, 1'b1, 1'b0);
    check("len_1", int'(prog_len), 1);
    fetch_one(0);
    check("fetch0_new", int'(fetch_data), 'h2A);
    fetch_one(1);
    check("fetch1_old", int'(fetch_data), 'h14);
    check("fetch1_old_oob", int'(fetch_oob), 1);

    // Randomised programs, noise and fetches
    for (int it = 0; it < 8; it++) begin
      int n;
      pulse_reload();
      n = $urandom_range(1, 32);
      for (int i = 0; i < 32; i++) ld_words[i] = 6'($urandom);
      load_seq(n, (n != 32) || ($urandom_range(0, 1) == 1), 1'b1);
      for (int c = 0; c < 40; c++) begin
        fetch_req = 1'($urandom); fetch_addr = 5'($urandom);
        load_valid = 1'($urandom); load_data = 6'($urandom);
        tick();
      end
      fetch_req = 1'b0; load_valid = 1'b0;
    end

    // Reset mid-load: fresh CLEAR wipes everything
    pulse_reload();
    for (int i = 0; i < 4; i++) ld_words[i] = 6'(6'h30 + i);
    load_seq(2, 1'b0, 1'b0);
    do_reset();
    check("valid_in_reset", int'(fetch_valid), 0);
    wait_ready("clear_cycles_again", 32);
    ld_words[0] = 6'h07;
    load_seq(1, 1'b1, 1'b0);
    for (int a = 1; a < 32; a++) begin
      fetch_one(a);
      check("cleared_word", int'(fetch_data), 0);
    end

`ifdef PROG_MEM_PARITY_EN
    fetch_one(0);
    check("perr_clean", int'(fetch_perr), 0);
    dut.mem_q[0][6] = ~dut.mem_q[0][6];
    fetch_one(0);
    check("perr_flip_valid", int'(fetch_valid), 1);
    check("perr_flip", int'(fetch_perr), 1);
`endif

    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
